fios_mm_ctrl: RTL

- Sequencer for the cascaded FIOS Montgomery multiplier datapath in EXPAND configuration, with one PE per word of a.
- Accepts one multiplication request through a start/ready handshake and latches the operands.
- Streams b/p words into the PE chain and generates staggered per-PE control enables and phase codes.
- Collects the s result words from the last PE and presents them with a one-cycle done pulse.

---
 rtl/fios_ctrl_pkg.sv | 39 +++
 rtl/ctrl_delay_chain.sv | 39 +++
 rtl/fios_mm_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fios_ctrl_pkg.sv
// Shared definitions for the FIOS Montgomery multiplier sequencer.
// Contents:
//   WORD_W    - datapath word width (17 bits)
//   phase_t   - per-PE phase code driven onto the PE chain
//   state_t   - sequencer FSM states
//   ctrl_t    - 4-bit per-PE control word {a_en, m_en, phase}
//   cnt_width - width of the sequencer cycle counter
package fios_ctrl_pkg;

  localparam int WORD_W = 17;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_FIRST = 2'd1,
    PH_MID   = 2'd2,
    PH_LAST  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_COLLECT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic   a_en;
    logic   m_en;
    phase_t phase;
  } ctrl_t;

  // The counter restarts on every state entry, so it only has to span the
  // longest single state; sizing it for the whole operation keeps it safe.
  function automatic int cnt_width(input int res_lat, input int words);
    return $clog2(res_lat + words + 2);
  endfunction

endpackage

// File: rtl/ctrl_delay_chain.sv
// Fixed-length delay line for one PE's control word.
// Ports:
//   clock        - system clock
//   reset        - synchronous active-high clear of every stage
//   ctrl_word    - control word of the previous PE
//   delayed_word - the same word DELAY cycles later
module ctrl_delay_chain
  import fios_ctrl_pkg::*;
#(
  parameter int DELAY = 9
) (
  input  logic  clock,
  input  logic  reset,
  input  ctrl_t ctrl_word,
  output ctrl_t delayed_word
);

  generate
    if (DELAY == 0) begin : g_pass
      assign delayed_word = ctrl_word;
    end else begin : g_shift
      ctrl_t stage [DELAY];

      // Stage 0 takes the incoming word; every stage hands its word one step
      // further each cycle. Clearing all stages drops any in-flight pulses.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DELAY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= ctrl_word;
          for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
        end
      end

      assign delayed_word = stage[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/fios_mm_ctrl.sv
// Sequencer for the cascaded FIOS Montgomery multiplier (EXPAND mode, one PE
// per word of a). Accepts one request, streams b/p words into PE0, staggers
// the per-PE controls down the chain and gathers the result words.
// Optional feature macro: FIOS_CTRL_PERF_CNT_EN (latency counter on
// last_latency_o; tied to 0 when undefined).
// Ports:
//   clock_i, reset_i            - clock, synchronous active-high reset
//   start_i / ready_o           - request handshake (ready_o high in IDLE)
//   a_i, b_i, p_i, p_prime_0_i  - operands, word 0 in the LSBs
//   mm_a_o, mm_p_prime_0_o      - latched a and p' for the datapath
//   mm_b_o, mm_p_o              - b/p word streamed during FEED, else 0
//   a_reg_en_o, m_reg_en_o      - per-PE load pulses
//   phase_o                     - per-PE phase code, 2 bits per PE
//   res_word_i                  - result word from the last PE
//   res_o, done_o               - collected result and its one-cycle strobe
//   busy_o                      - high whenever not IDLE
//   last_latency_o              - cycles from acceptance to done_o
module fios_mm_ctrl
  import fios_ctrl_pkg::*;
#(
  parameter int s        = 8,
  parameter int PE_DELAY = 9,
  parameter int M_OFFSET = 3,
  parameter int RES_LAT  = 76
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  ready_o,
  input  logic [s*WORD_W-1:0]   a_i,
  input  logic [s*WORD_W-1:0]   b_i,
  input  logic [s*WORD_W-1:0]   p_i,
  input  logic [WORD_W-1:0]     p_prime_0_i,
  output logic [s*WORD_W-1:0]   mm_a_o,
  output logic [WORD_W-1:0]     mm_b_o,
  output logic [WORD_W-1:0]     mm_p_o,
  output logic [WORD_W-1:0]     mm_p_prime_0_o,
  output logic [s-1:0]          a_reg_en_o,
  output logic [s-1:0]          m_reg_en_o,
  output logic [2*s-1:0]        phase_o,
  input  logic [WORD_W-1:0]     res_word_i,
  output logic [s*WORD_W-1:0]   res_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [15:0]           last_latency_o
);

  localparam int CNT_W     = cnt_width(RES_LAT, s);
  localparam int DRAIN_LEN = RES_LAT - s;
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(s - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

  generate
    if (RES_LAT < s) begin : g_bad_res_lat
      $error("fios_mm_ctrl: RES_LAT must not be smaller than s");
    end
  endgenerate

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic accept, feeding, feed_start, m_start;

  logic [s*WORD_W-1:0] a_reg, b_shift, p_shift, res_reg;
  logic [WORD_W-1:0]   pp_reg;

  ctrl_t pe0_ctrl;
  ctrl_t pe_ctrl [s];

  assign accept     = (state == ST_IDLE) && start_i;
  assign feeding    = (state == ST_FEED);
  assign feed_start = feeding && (cnt == '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter restarts on each state entry and indexes the word within
  // FEED and COLLECT. DRAIN is skipped when the result latency equals s.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    unique case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (start_i) state_next = ST_FEED;
      end
      ST_FEED: begin
        if (cnt == WORD_LAST) begin
          cnt_next   = '0;
          state_next = (DRAIN_LEN == 0) ? ST_COLLECT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cnt == WORD_LAST) begin
          cnt_next   = '0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // b and p are shifted down one word per FEED cycle so the current word is
  // always in the LSBs. Result words land at the slot given by the counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      a_reg   <= '0;
      b_shift <= '0;
      p_shift <= '0;
      pp_reg  <= '0;
      res_reg <= '0;
    end else begin
      if (accept) begin
        a_reg   <= a_i;
        b_shift <= b_i;
        p_shift <= p_i;
        pp_reg  <= p_prime_0_i;
      end else if (feeding) begin
        b_shift <= b_shift >> WORD_W;
        p_shift <= p_shift >> WORD_W;
      end
      if (state == ST_COLLECT) res_reg[int'(cnt)*WORD_W +: WORD_W] <= res_word_i;
    end
  end

  // m_reg_en of PE0 trails the first feed cycle by M_OFFSET cycles; it runs
  // from its own pipe so it still fires if FEED is shorter than the offset.
  generate
    if (M_OFFSET == 0) begin : g_m_direct
      assign m_start = feed_start;
    end else begin : g_m_pipe
      logic [M_OFFSET-1:0] m_pipe;
      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          m_pipe <= '0;
        end else begin
          m_pipe[0] <= feed_start;
          for (int i = 1; i < M_OFFSET; i++) m_pipe[i] <= m_pipe[i-1];
        end
      end
      assign m_start = m_pipe[M_OFFSET-1];
    end
  endgenerate

  // With s=1 the only word is both first and last; FIRST wins.
  always_comb begin
    pe0_ctrl       = '0;
    pe0_ctrl.m_en  = m_start;
    if (feeding) begin
      pe0_ctrl.a_en = (cnt == '0);
      if (cnt == '0)            pe0_ctrl.phase = PH_FIRST;
      else if (cnt == WORD_LAST) pe0_ctrl.phase = PH_LAST;
      else                       pe0_ctrl.phase = PH_MID;
    end
  end

  assign pe_ctrl[0] = pe0_ctrl;

  generate
    for (genvar k = 1; k < s; k++) begin : g_pe_delay
      ctrl_delay_chain #(
        .DELAY(PE_DELAY)
      ) u_delay (
        .clock       (clock_i),
        .reset       (reset_i),
        .ctrl_word   (pe_ctrl[k-1]),
        .delayed_word(pe_ctrl[k])
      );
    end
    for (genvar k = 0; k < s; k++) begin : g_pe_out
      assign a_reg_en_o[k]      = pe_ctrl[k].a_en;
      assign m_reg_en_o[k]      = pe_ctrl[k].m_en;
      assign phase_o[2*k +: 2]  = pe_ctrl[k].phase;
    end
  endgenerate

  assign ready_o        = (state == ST_IDLE);
  assign busy_o         = (state != ST_IDLE);
  assign done_o         = (state == ST_DONE);
  assign mm_a_o         = a_reg;
  assign mm_p_prime_0_o = pp_reg;
  assign mm_b_o         = feeding ? b_shift[WORD_W-1:0] : '0;
  assign mm_p_o         = feeding ? p_shift[WORD_W-1:0] : '0;
  assign res_o          = res_reg;

`ifdef FIOS_CTRL_PERF_CNT_EN
  logic [15:0] perf_cnt, last_lat;

  // perf_cnt reads 1 in the first busy cycle, so at done_o it holds the
  // number of cycles since acceptance; both counters saturate.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_cnt <= '0;
      last_lat <= '0;
    end else begin
      if (accept) perf_cnt <= 16'd1;
      else if (busy_o && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
      if (done_o) last_lat <= perf_cnt;
    end
  end

  assign last_latency_o = last_lat;
`else
  assign last_latency_o = '0;
`endif

endmodule
